// File: rtl/mdom_wvb_hdr_pkg.sv
// Shared definitions for the waveform-buffer header reader: bundle field map,
// FSM state encoding and the header word mux.
package mdom_wvb_hdr_pkg;

    localparam int P_HDR_W   = 103;
    localparam int P_WORD_W  = 16;
    localparam int P_N_WORDS = 7;

    localparam int LTC_LSB   = 0;
    localparam int LTC_W     = 49;
    localparam int START_LSB = 49;
    localparam int ADDR_W    = 11;
    localparam int STOP_LSB  = 60;
    localparam int TRIG_LSB  = 71;
    localparam int TRIG_W    = 2;
    localparam int CNST_LSB  = 73;
    localparam int PRE_LSB   = 74;
    localparam int PRE_W     = 5;
    localparam int SYNC_LSB  = 79;
    localparam int BSUM_LSB  = 80;
    localparam int BSUM_W    = 19;
    localparam int BLS_LSB   = 99;
    localparam int BLS_W     = 3;
    localparam int BV_LSB    = 102;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_SEND,
        S_PULSE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [LTC_W-1:0]  ltc;
        logic [ADDR_W-1:0] start_addr;
        logic [ADDR_W-1:0] stop_addr;
        logic [TRIG_W-1:0] trig_src;
        logic              cnst_run;
        logic [PRE_W-1:0]  pre_conf;
        logic              sync_rdy;
        logic [BSUM_W-1:0] bsum;
        logic [BLS_W-1:0]  bsum_len_sel;
        logic              bsum_valid;
    } hdr_fields_t;

    // Stream word idx of an unpacked header; w0 goes out first, padding is zero.
    function automatic logic [P_WORD_W-1:0] hdr_word(input hdr_fields_t f, input logic [2:0] idx);
        logic [P_WORD_W-1:0] w;
        case (idx)
            3'd0:    w = f.ltc[47:32];
            3'd1:    w = f.ltc[31:16];
            3'd2:    w = f.ltc[15:0];
            3'd3:    w = {f.ltc[48], 4'b0, f.start_addr};
            3'd4:    w = {f.trig_src, f.cnst_run, f.sync_rdy, 1'b0, f.stop_addr};
            3'd5:    w = {f.bsum_valid, f.bsum_len_sel, f.pre_conf, 4'b0, f.bsum[18:16]};
            3'd6:    w = f.bsum[15:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mdom_wvb_hdr_unpack.sv
// Combinational split of a packed header bundle into its fields; exact
// inverse of the writer-side fan-in.
module mdom_wvb_hdr_unpack
    import mdom_wvb_hdr_pkg::*;
(
    input  logic [P_HDR_W-1:0] hdr_i,
    output logic [LTC_W-1:0]   ltc_o,
    output logic [ADDR_W-1:0]  start_addr_o,
    output logic [ADDR_W-1:0]  stop_addr_o,
    output logic [TRIG_W-1:0]  trig_src_o,
    output logic               cnst_run_o,
    output logic [PRE_W-1:0]   pre_conf_o,
    output logic               sync_rdy_o,
    output logic [BSUM_W-1:0]  bsum_o,
    output logic [BLS_W-1:0]   bsum_len_sel_o,
    output logic               bsum_valid_o
);

    assign ltc_o          = hdr_i[LTC_LSB   +: LTC_W];
    assign start_addr_o   = hdr_i[START_LSB +: ADDR_W];
    assign stop_addr_o    = hdr_i[STOP_LSB  +: ADDR_W];
    assign trig_src_o     = hdr_i[TRIG_LSB  +: TRIG_W];
    assign cnst_run_o     = hdr_i[CNST_LSB];
    assign pre_conf_o     = hdr_i[PRE_LSB   +: PRE_W];
    assign sync_rdy_o     = hdr_i[SYNC_LSB];
    assign bsum_o         = hdr_i[BSUM_LSB  +: BSUM_W];
    assign bsum_len_sel_o = hdr_i[BLS_LSB   +: BLS_W];
    assign bsum_valid_o   = hdr_i[BV_LSB];

endmodule

// File: rtl/mdom_wvb_hdr_reader.sv
// Waveform-buffer header reader: pops one header bundle per event, streams it
// as 7 x 16-bit words, then hands addresses to the payload reader and waits.
module mdom_wvb_hdr_reader
    import mdom_wvb_hdr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                hdr_empty,
    output logic                hdr_rdreq,
    input  logic [P_HDR_W-1:0]  hdr_data,
    output logic [P_WORD_W-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [ADDR_W-1:0]   wvb_start_addr,
    output logic [ADDR_W-1:0]   wvb_stop_addr,
    output logic                wvb_rd_go,
    input  logic                wvb_rd_done,
    output logic                busy
);

    localparam logic [2:0] LAST_WORD = 3'(P_N_WORDS - 1);

    hdr_fields_t         unp;
    hdr_fields_t         fld_q;
    state_t              state_q;
    logic [2:0]          cnt_q;
    logic [P_WORD_W-1:0] dout_q;
    logic                dout_valid_q;
    logic                rdreq_q;
    logic                go_q;
    logic                busy_q;

    mdom_wvb_hdr_unpack u_unpack (
        .hdr_i          (hdr_data),
        .ltc_o          (unp.ltc),
        .start_addr_o   (unp.start_addr),
        .stop_addr_o    (unp.stop_addr),
        .trig_src_o     (unp.trig_src),
        .cnst_run_o     (unp.cnst_run),
        .pre_conf_o     (unp.pre_conf),
        .sync_rdy_o     (unp.sync_rdy),
        .bsum_o         (unp.bsum),
        .bsum_len_sel_o (unp.bsum_len_sel),
        .bsum_valid_o   (unp.bsum_valid)
    );

    // dout is registered one word ahead: LATCH loads w0 straight from the
    // FIFO output, each accept loads the next word from the field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fld_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rdreq_q      <= 1'b0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rdreq_q <= 1'b0;
            go_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en && !hdr_empty) begin
                        state_q <= S_RD;
                        rdreq_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_RD: state_q <= S_LATCH;
                S_LATCH: begin
                    fld_q        <= unp;
                    cnt_q        <= '0;
                    dout_q       <= hdr_word(unp, 3'd0);
                    dout_valid_q <= 1'b1;
                    state_q      <= S_SEND;
                end
                S_SEND: begin
                    if (dout_ready) begin
                        if (cnt_q == LAST_WORD) begin
                            cnt_q        <= '0;
                            dout_q       <= '0;
                            dout_valid_q <= 1'b0;
                            go_q         <= 1'b1;
                            state_q      <= S_PULSE;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            dout_q <= hdr_word(fld_q, cnt_q + 3'd1);
                        end
                    end
                end
                S_PULSE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (wvb_rd_done) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hdr_rdreq      = rdreq_q;
    assign dout           = dout_q;
    assign dout_valid     = dout_valid_q;
    assign wvb_start_addr = fld_q.start_addr;
    assign wvb_stop_addr  = fld_q.stop_addr;
    assign wvb_rd_go      = go_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mdom_wvb_hdr_reader.sv
// Directed bench for mdom_wvb_hdr_reader: FIFO model, accepted-word capture
// and per-scenario tasks with hand-computed expected words.
module tb_mdom_wvb_hdr_reader;

    logic         clk, rst, en, hdr_empty, hdr_rdreq;
    logic [102:0] hdr_data;
    logic [15:0]  dout;
    logic         dout_valid, dout_ready, wvb_rd_go, wvb_rd_done, busy;
    logic [10:0]  sa, sp;

    int n_chk  = 0;
    int n_pass = 0;

    logic [102:0] fifo [0:7];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic [15:0]  acc [0:255];
    int           n_acc  = 0;
    int           go_cnt = 0;

    // B1/E1 and B2/E2: bundles and their hand-derived word streams (w0..w6)
    logic [102:0] B1, B2;
    localparam logic [111:0] E1 = 112'h2345_6789_ABCD_8010_57FF_D985_A5A5;
    localparam logic [111:0] E2 = 112'h1111_2222_3333_0123_E456_2F87_0F0F;

    mdom_wvb_hdr_reader dut (
        .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
        .hdr_data(hdr_data), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .wvb_start_addr(sa), .wvb_stop_addr(sp), .wvb_rd_go(wvb_rd_go),
        .wvb_rd_done(wvb_rd_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign hdr_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (hdr_rdreq) begin
            hdr_data <= fifo[rd_ptr % 8];
            rd_ptr   <= rd_ptr + 1;
        end
        if (dout_valid && dout_ready) begin
            acc[n_acc % 256] <= dout;
            n_acc            <= n_acc + 1;
        end
        if (wvb_rd_go) go_cnt <= go_cnt + 1;
    end

    function automatic logic [102:0] mk(input logic [48:0] ltc, input logic [10:0] s, input logic [10:0] e,
                                        input logic [1:0] trig, input logic cnst, input logic [4:0] pre,
                                        input logic sync, input logic [18:0] bsum, input logic [2:0] bls,
                                        input logic bv);
        return {bv, bls, bsum, sync, pre, cnst, trig, e, s, ltc};
    endfunction

    function automatic logic [111:0] words_at(input int b);
        return {acc[b % 256], acc[(b+1) % 256], acc[(b+2) % 256], acc[(b+3) % 256],
                acc[(b+4) % 256], acc[(b+5) % 256], acc[(b+6) % 256]};
    endfunction

    task automatic push(input logic [102:0] b);
        fifo[wr_ptr % 8] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_go(input int g0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (go_cnt > g0) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (dout_valid) ok = 1'b1;
        end
    endtask

    task automatic pulse_done();
        wvb_rd_done = 1'b1;
        @(negedge clk);
        wvb_rd_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_event(input logic [102:0] b, output logic [111:0] w, output bit ok);
        int base, g0;
        base = n_acc;
        g0   = go_cnt;
        push(b);
        wait_go(g0, ok);
        w = words_at(base);
        pulse_done();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({dout_valid, hdr_rdreq, wvb_rd_go, busy} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000", {dout_valid, hdr_rdreq, wvb_rd_go, busy});
        else n_pass++;
        n_chk++;
        if (dout !== 16'h0) $display("FAIL reset_dout: got %h want 0000", dout);
        else n_pass++;
        n_chk++;
        if ({sa, sp} !== 22'h0) $display("FAIL reset_addr: got %h/%h want 0/0", sa, sp);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base, g0, nv;
        bit found;
        base = n_acc;
        g0   = go_cnt;
        push(B1);
        en = 1'b1;
        dout_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (hdr_rdreq) found = 1'b1;
        end
        n_chk++;
        if (!found) $display("FAIL single_rdreq: got no hdr_rdreq want one");
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({dout_valid, dout} !== {1'b1, 16'h2345})
            $display("FAIL single_latency: got v=%b d=%h want v=1 d=2345", dout_valid, dout);
        else n_pass++;
        nv = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dout_valid) break;
            nv++;
        end
        n_chk++;
        if (nv != 7) $display("FAIL single_stream_len: got %0d want 7", nv);
        else n_pass++;
        n_chk++;
        if (wvb_rd_go !== 1'b1) $display("FAIL single_go: got %b want 1", wvb_rd_go);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({wvb_rd_go, busy} !== 2'b01) $display("FAIL single_go_width: got go/busy=%b want 01", {wvb_rd_go, busy});
        else n_pass++;
        n_chk++;
        if ({sa, sp} !== {11'h010, 11'h7FF}) $display("FAIL single_addr: got %h/%h want 010/7ff", sa, sp);
        else n_pass++;
        n_chk++;
        if (words_at(base) !== E1 || go_cnt != g0 + 1)
            $display("FAIL single_words: got %h want %h", words_at(base), E1);
        else n_pass++;
        pulse_done();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, g0, stable_err;
        logic pv, pr;
        logic [15:0] pd;
        base = n_acc;
        g0   = go_cnt;
        stable_err = 0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        dout_ready = 1'b0;
        push(B2);
        for (int i = 0; i < 100 && go_cnt == g0; i++) begin
            @(negedge clk);
            if (pv && !pr && (!dout_valid || dout !== pd)) stable_err++;
            pv = dout_valid;
            pd = dout;
            dout_ready = ~dout_ready;
            pr = dout_ready;
        end
        n_chk++;
        if (go_cnt != g0 + 1) $display("FAIL bp_timeout: got go_cnt %0d want %0d", go_cnt, g0 + 1);
        else n_pass++;
        n_chk++;
        if (stable_err != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_err);
        else n_pass++;
        n_chk++;
        if (n_acc - base != 7) $display("FAIL bp_accepts: got %0d want 7", n_acc - base);
        else n_pass++;
        n_chk++;
        if (words_at(base) !== E2) $display("FAIL bp_words: got %h want %h", words_at(base), E2);
        else n_pass++;
        dout_ready = 1'b1;
        @(negedge clk);
        pulse_done();
    endtask

    task automatic test_field_iso();
        int lsb [10] = '{0, 49, 60, 71, 73, 74, 79, 80, 99, 102};
        int wid [10] = '{49, 11, 11, 2, 1, 5, 1, 19, 3, 1};
        logic [111:0] ex [10];
        logic [102:0] one, m;
        logic [111:0] w;
        bit ok;
        ex[0] = 112'hFFFF_FFFF_FFFF_8000_0000_0000_0000;
        ex[1] = 112'h0000_0000_0000_07FF_0000_0000_0000;
        ex[2] = 112'h0000_0000_0000_0000_07FF_0000_0000;
        ex[3] = 112'h0000_0000_0000_0000_C000_0000_0000;
        ex[4] = 112'h0000_0000_0000_0000_2000_0000_0000;
        ex[5] = 112'h0000_0000_0000_0000_0000_0F80_0000;
        ex[6] = 112'h0000_0000_0000_0000_1000_0000_0000;
        ex[7] = 112'h0000_0000_0000_0000_0000_0007_FFFF;
        ex[8] = 112'h0000_0000_0000_0000_0000_7000_0000;
        ex[9] = 112'h0000_0000_0000_0000_0000_8000_0000;
        one = 103'd1;
        dout_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            m = ((one << wid[k]) - one) << lsb[k];
            run_event(m, w, ok);
            n_chk++;
            if (!ok || w !== ex[k]) $display("FAIL field_iso_%0d: got %h want %h", k, w, ex[k]);
            else n_pass++;
        end
    endtask

    task automatic test_flow();
        int base, g0, r0, err;
        bit ok;
        base = n_acc;
        g0   = go_cnt;
        r0   = rd_ptr;
        err  = 0;
        push(B1);
        push(B2);
        wait_go(g0, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hdr_rdreq || rd_ptr != r0 + 1 || sa !== 11'h010 || sp !== 11'h7FF) err++;
        end
        n_chk++;
        if (!ok || err != 0) $display("FAIL flow_wait_hold: got %0d violations (go ok=%0d) want 0", err, ok);
        else n_pass++;
        n_chk++;
        if (words_at(base) !== E1) $display("FAIL flow_words1: got %h want %h", words_at(base), E1);
        else n_pass++;
        wvb_rd_done = 1'b1;
        @(negedge clk);
        wvb_rd_done = 1'b0;
        n_chk++;
        if ({busy, hdr_rdreq} !== 2'b00) $display("FAIL flow_idle_gap: got busy/rdreq=%b want 00", {busy, hdr_rdreq});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (hdr_rdreq !== 1'b1) $display("FAIL flow_second_rdreq: got %b want 1", hdr_rdreq);
        else n_pass++;
        wait_go(g0 + 1, ok);
        n_chk++;
        if (!ok || words_at(base + 7) !== E2) $display("FAIL flow_words2: got %h want %h", words_at(base + 7), E2);
        else n_pass++;
        n_chk++;
        if ({sa, sp} !== {11'h123, 11'h456}) $display("FAIL flow_addr2: got %h/%h want 123/456", sa, sp);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_abort();
        int base, g0;
        bit ok;
        dout_ready = 1'b1;
        push(B1);
        wait_valid(ok);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        n_chk++;
        if (!ok || dout !== 16'h8010) $display("FAIL abort_at_w3: got %h want 8010", dout);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({dout, dout_valid, hdr_rdreq, wvb_rd_go, busy, sa, sp} !== 42'h0)
            $display("FAIL abort_clear: got d=%h v=%b busy=%b addr=%h/%h want all 0", dout, dout_valid, busy, sa, sp);
        else n_pass++;
        push(B2);
        @(negedge clk);
        rst = 1'b0;
        dout_ready = 1'b1;
        base = n_acc;
        g0   = go_cnt;
        wait_valid(ok);
        n_chk++;
        if (!ok || dout !== 16'h1111) $display("FAIL abort_restart_w0: got %h want 1111", dout);
        else n_pass++;
        wait_go(g0, ok);
        n_chk++;
        if (!ok || words_at(base) !== E2) $display("FAIL abort_words: got %h want %h", words_at(base), E2);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_guards();
        int r0, base, g0, seen;
        bit ok;
        r0 = rd_ptr;
        seen = 0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hdr_rdreq || busy) seen++;
        end
        n_chk++;
        if (seen != 0 || rd_ptr != r0) $display("FAIL guard_empty: got %0d activity cycles want 0", seen);
        else n_pass++;
        en = 1'b0;
        push(B1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hdr_rdreq || busy) seen++;
        end
        n_chk++;
        if (seen != 0 || rd_ptr != r0) $display("FAIL guard_en_low: got %0d activity cycles want 0", seen);
        else n_pass++;
        base = n_acc;
        g0   = go_cnt;
        en = 1'b1;
        wait_valid(ok);
        en = 1'b0;
        @(negedge clk);
        wvb_rd_done = 1'b1;
        @(negedge clk);
        wvb_rd_done = 1'b0;
        wait_go(g0, ok);
        n_chk++;
        if (!ok || words_at(base) !== E1) $display("FAIL guard_spurious_done: got %h want %h", words_at(base), E1);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL guard_wait_hold: got busy=%b want 1", busy);
        else n_pass++;
        pulse_done();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL guard_release: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        dout_ready = 1'b0;
        wvb_rd_done = 1'b0;
        B1 = mk(49'h1_2345_6789_ABCD, 11'h010, 11'h7FF, 2'b01, 1'b0, 5'h13, 1'b1, 19'h5_A5A5, 3'b101, 1'b1);
        B2 = mk(49'h0_1111_2222_3333, 11'h123, 11'h456, 2'b11, 1'b1, 5'h1F, 1'b0, 19'h7_0F0F, 3'b010, 1'b0);
        test_reset();
        test_single();
        test_backpressure();
        test_field_iso();
        test_flow();
        test_abort();
        test_guards();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
